// File: rtl/rgb_led_pkg.sv
// Shared types and frame constants for the single-wire RGB LED transmitter.
package rgb_led_pkg;

  localparam int COLOUR_W       = 24;
  localparam int BITS_PER_FRAME = 24;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    LATCH
  } tx_state_t;

  typedef logic [COLOUR_W-1:0] colour_t;

endpackage

// File: rtl/led_bit_timer.sv
// Per-bit period timer: counts one bit period and drives the registered
// pulse-width-coded LED data level.
module led_bit_timer #(
  parameter int BIT_CYCLES = 125,
  parameter int T0H        = 40,
  parameter int T1H        = 80
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic bit_val,
  output logic dout,
  output logic bit_done
);

  localparam int CW = $clog2(BIT_CYCLES);
  localparam logic [CW-1:0] LAST_CNT = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] T0_CNT   = CW'(T0H);
  localparam logic [CW-1:0] T1_CNT   = CW'(T1H);

  logic [CW-1:0] cnt, cnt_nxt;
  logic          active, active_nxt;
  logic          high_nxt;

  assign bit_done = active && (cnt == LAST_CNT);

  // bit_val describes the bit that will be on the line in the next cycle,
  // so the registered level lines up with the counter value it encodes.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    cnt_nxt    = cnt;
    active_nxt = active;
    if (start) begin
      cnt_nxt    = '0;
      active_nxt = 1'b1;
    end else if (active) begin
      if (cnt == LAST_CNT) begin
        cnt_nxt    = '0;
        active_nxt = 1'b0;
      end else begin
        cnt_nxt = cnt + CW'(1);
      end
    end
    high_nxt = active_nxt && (cnt_nxt < (bit_val ? T1_CNT : T0_CNT));
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      active <= 1'b0;
      dout   <= 1'b0;
    end else begin
      cnt    <= cnt_nxt;
      active <= active_nxt;
      dout   <= high_nxt;
    end
  end

endmodule

// File: rtl/rgb_led_tx.sv
// Serial transmitter for addressable RGB LEDs: 24 coded bits then a latch gap.
// Define RGB_LED_TX_GRB_EN to send the colour word in G, R, B byte order.
module rgb_led_tx
  import rgb_led_pkg::*;
#(
  parameter int BIT_CYCLES   = 125,
  parameter int T0H          = 40,
  parameter int T1H          = 80,
  parameter int LATCH_CYCLES = 5000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [COLOUR_W-1:0] colour,
  input  logic                valid,
  output logic                ready,
  output logic                dout,
  output logic                busy
);

  if (!(T0H > 0 && T0H < T1H && T1H < BIT_CYCLES && LATCH_CYCLES >= 1)) begin : g_bad_params
    $error("rgb_led_tx: illegal timing parameters");
  end

  localparam int IW = $clog2(BITS_PER_FRAME);
  localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
  localparam logic [IW-1:0] LAST_BIT   = IW'(BITS_PER_FRAME - 1);
  localparam logic [LW-1:0] LAST_LATCH = LW'(LATCH_CYCLES - 1);

  tx_state_t     state, state_nxt;
  colour_t       sreg, load_word;
  logic [IW-1:0] bit_idx;
  logic [LW-1:0] lcnt, lcnt_nxt;
  logic          ready_nxt;
  logic          accept, start_bit, bit_val, bit_done;

`ifdef RGB_LED_TX_GRB_EN
  assign load_word = {colour[15:8], colour[23:16], colour[7:0]};
`else
  assign load_word = colour;
`endif

  assign accept    = valid && ready;
  assign start_bit = accept || (state == SEND && bit_done && bit_idx != LAST_BIT);
  assign bit_val   = accept   ? load_word[COLOUR_W-1] :
                     bit_done ? sreg[COLOUR_W-2] : sreg[COLOUR_W-1];

  led_bit_timer #(
    .BIT_CYCLES (BIT_CYCLES),
    .T0H        (T0H),
    .T1H        (T1H)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (start_bit),
    .bit_val  (bit_val),
    .dout     (dout),
    .bit_done (bit_done)
  );

  // ready is raised for the final latch cycle so a back-to-back frame starts
  // exactly LATCH_CYCLES low cycles after the previous frame's last bit.
  always_comb begin
    state_nxt = state;
    lcnt_nxt  = lcnt;
    unique case (state)
      IDLE: begin
        if (accept) state_nxt = SEND;
      end
      SEND: begin
        lcnt_nxt = '0;
        if (bit_done && bit_idx == LAST_BIT) state_nxt = LATCH;
      end
      LATCH: begin
        if (lcnt == LAST_LATCH) begin
          lcnt_nxt  = '0;
          state_nxt = accept ? SEND : IDLE;
        end else begin
          lcnt_nxt = lcnt + LW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
    ready_nxt = (state_nxt == IDLE) || (state_nxt == LATCH && lcnt_nxt == LAST_LATCH);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      lcnt  <= '0;
      ready <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      lcnt  <= lcnt_nxt;
      ready <= ready_nxt;
      busy  <= !ready_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg    <= '0;
      bit_idx <= '0;
    end else if (accept) begin
      sreg    <= load_word;
      bit_idx <= '0;
    end else if (state == SEND && bit_done) begin
      sreg    <= sreg << 1;
      bit_idx <= (bit_idx == LAST_BIT) ? '0 : bit_idx + IW'(1);
    end
  end

endmodule

// File: tb/tb_rgb_led_tx.sv
// Scoreboard bench for rgb_led_tx: a frame-level model predicts ready/busy
// timing and the wire word; a monitor decodes dout and compares.
module tb_rgb_led_tx;
  import rgb_led_pkg::*;

  localparam int B     = 10;
  localparam int T0    = 3;
  localparam int T1    = 7;
  localparam int L     = 20;
  localparam int FRAME = BITS_PER_FRAME * B;
  localparam int TURN  = FRAME + L;

  typedef struct {
    colour_t word;
    int      k;
  } frame_t;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  logic    valid = 1'b0;
  colour_t colour = '0;
  logic    ready, dout, busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int model_k  = -1;
  int accepts  = 0;
  int mj;
  bit exp_ready;
  frame_t sb_q[$];

  // monitor state
  logic [FRAME-1:0] samples;
  bit      mon_active = 1'b0;
  int      mon_n = 0;
  int      mon_gap = -1;
  int      last_k = -1000000;
  frame_t  cur;
  colour_t dec;
  int      wave_err, hi, k0, start_acc;
  bit      exp_bit;

  rgb_led_tx #(
    .BIT_CYCLES   (B),
    .T0H          (T0),
    .T1H          (T1),
    .LATCH_CYCLES (L)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .colour (colour),
    .valid  (valid),
    .ready  (ready),
    .dout   (dout),
    .busy   (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Order in which the three colour bytes appear on the wire.
  function automatic colour_t wire_order(input colour_t c);
    logic [7:0] r, g, b;
    r = c[23:16];
    g = c[15:8];
    b = c[7:0];
`ifdef RGB_LED_TX_GRB_EN
    return {g, r, b};
`else
    return {r, g, b};
`endif
  endfunction

  // Frame-level model: one frame occupies TURN cycles after its accept edge;
  // ready is high from the TURN-th cycle on, and dout is low past the 24 bits.
  always @(negedge clk) begin
    if (rst) begin
      model_k = -1;
      sb_q.delete();
    end else begin
      mj        = (model_k < 0) ? TURN : cyc - model_k + 1;
      exp_ready = (mj >= TURN);
      check("ready", ready, exp_ready);
      check("busy", busy, !exp_ready);
      if (mj > FRAME) check("dout_low", dout, 0);
      if (exp_ready && valid) begin
        model_k = cyc + 1;
        sb_q.push_back('{wire_order(colour), cyc + 1});
        accepts++;
      end
    end
  end

  // Monitor: collect 24 bit periods from the first rising sample, decode by
  // high time and compare with the scoreboard entry.
  always @(negedge clk) begin
    if (rst) begin
      mon_active = 1'b0;
      mon_n      = 0;
      mon_gap    = -1;
    end else if (mon_active) begin
      samples[mon_n] = dout;
      mon_n++;
      if (mon_n == FRAME) begin
        dec      = '0;
        wave_err = 0;
        for (int n = 0; n < BITS_PER_FRAME; n++) begin
          hi      = 0;
          exp_bit = cur.word[BITS_PER_FRAME-1-n];
          for (int p = 0; p < B; p++) begin
            hi += int'(samples[n*B+p]);
            if (samples[n*B+p] !== (p < (exp_bit ? T1 : T0))) wave_err++;
          end
          dec[BITS_PER_FRAME-1-n] = (hi * 2 > T0 + T1);
        end
        check("frame_word", dec, cur.word);
        check("frame_wave_errors", wave_err, 0);
        mon_active = 1'b0;
        mon_gap    = 0;
        last_k     = cur.k;
      end
    end else if (dout) begin
      check("sb_depth_at_rise", sb_q.size(), 1);
      if (sb_q.size() > 0) begin
        cur = sb_q.pop_front();
        check("rise_latency", cyc - cur.k + 1, 1);
        if (mon_gap >= 0 && cur.k == last_k + TURN) check("latch_gap", mon_gap, L);
        samples[0] = 1'b1;
        mon_n      = 1;
        mon_active = 1'b1;
      end
      mon_gap = -1;
    end else if (mon_gap >= 0) begin
      mon_gap++;
    end
  end

  task automatic send(input colour_t c);
    int s;
    s = accepts;
    @(posedge clk);
    #1;
    colour = c;
    valid  = 1'b1;
    for (int t = 0; t < 2 * TURN && accepts == s; t++) @(posedge clk);
    #1 valid = 1'b0;
    check("accept", accepts, s + 1);
  endtask

  task automatic idle_out();
    repeat (TURN + 5) @(posedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_dout", dout, 0);
    check("reset_ready", ready, 1);
    check("reset_busy", busy, 0);
    rst = 1'b0;
    repeat (50) @(posedge clk);
    #1 check("idle_ready", ready, 1);

    // Single frame with a stray request in the middle and a ready-return check.
    send(24'hFF0000);
    k0 = model_k;
    repeat (48) @(posedge clk);
    #1;
    colour = 24'h00FF00;
    valid  = 1'b1;
    @(posedge clk);
    #1 valid = 1'b0;
    for (int t = 0; t < 2 * TURN && !ready; t++) @(negedge clk);
    check("ready_return", cyc - k0 + 1, TURN);
    idle_out();

    // Held valid: two back-to-back frames.
    start_acc = accepts;
    @(posedge clk);
    #1;
    colour = 24'hA5A5A5;
    valid  = 1'b1;
    for (int t = 0; t < 3 * TURN && accepts < start_acc + 2; t++) @(posedge clk);
    #1 valid = 1'b0;
    check("hold_two_frames", accepts - start_acc, 2);
    idle_out();

    // Random colours with random idle spacing; some requests land while busy.
    for (int i = 0; i < 6; i++) begin
      repeat ($urandom_range(0, 40)) @(posedge clk);
      send(colour_t'($urandom));
    end
    idle_out();

    send(24'h123456);
    idle_out();

    // Asynchronous reset during the high phase of bit 10.
    send(colour_t'($urandom));
    k0 = model_k;
    for (int t = 0; t < TURN && (cyc - k0 + 1) != 10 * B + 2; t++) @(negedge clk);
    check("pre_reset_dout", dout, 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_dout", dout, 0);
    check("async_rst_ready", ready, 1);
    check("async_rst_busy", busy, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    send(24'h000001);
    idle_out();

    check("sb_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rgb_led_tx.md
# rgb_led_tx

Serial single-wire transmitter for addressable RGB LEDs. Accepts the 24-bit colour word produced by the doorbell chime light selector and shifts it out as 24 pulse-width-coded bits followed by a latch gap. It sits between the colour selector and the LED strip pin, and is the physical-output end of the 24-bit colour interface.

## Interface
- `BIT_CYCLES`, 125: clock cycles per bit period (1.25 us at 100 MHz).
- `T0H`, 40: high cycles for a 0 bit.
- `T1H`, 80: high cycles for a 1 bit.
- `LATCH_CYCLES`, 5000: low cycles after the 24th bit before the next frame is accepted.
- Legal only if 0 < `T0H` < `T1H` < `BIT_CYCLES` and `LATCH_CYCLES` ≥ 1. Violations are elaboration errors.

- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `colour` input 24: colour word, {R,G,B}; sampled only on acceptance.
- `valid` input 1: `colour` is presented for transmission.
- `ready` output 1: block is idle and accepts on this cycle.
- `dout` output 1: serial LED data line, registered.
- `busy` output 1: frame or latch gap in progress; equals `!ready`.

## Operation
- FSM states:
  - IDLE: `ready`=1, `dout`=0.
  - SEND: 24 bits, MSB first.
  - LATCH: `dout`=0 for `LATCH_CYCLES`.
- Transitions:
  - IDLE→SEND on a rising edge with `valid && ready`. The colour is latched into a 24-bit shift register, the bit index is cleared and the cycle counter is cleared.
  - SEND: the cycle counter counts 0..`BIT_CYCLES`-1. At wrap, the shift register shifts left and the bit index increments. After bit index 23 wraps, the FSM goes SEND→LATCH.
  - LATCH→IDLE when the latch counter reaches `LATCH_CYCLES`-1.
- Bit waveform: `dout`=1 while cycle counter < (current bit ? `T1H` : `T0H`), else 0.
- `colour` and `valid` are ignored outside IDLE. There is no queueing, and a dropped request is the requester's responsibility.
- Counter widths are `$clog2` of the respective maximum. Counters wrap only at their terminal count and never free-run.
- Reset, at any time including mid-bit or mid-latch, takes effect immediately:
  - outputs go to `dout`=0, `ready`=1, `busy`=0;
  - the FSM goes to IDLE;
  - all counters and the shift register clear;
  - the frame in progress is abandoned, not resumed.

## Timing
- The acceptance edge is edge k.
- `dout` rises in the cycle after edge k. Latency to first high is 1 cycle.
- Bit n occupies cycles k+1+n·`BIT_CYCLES` through k+(n+1)·`BIT_CYCLES`.
- `ready` reasserts exactly 24·`BIT_CYCLES`+`LATCH_CYCLES` cycles after edge k. A new frame may be accepted on that same cycle's closing edge.
- Back-to-back frames therefore have exactly `LATCH_CYCLES` low cycles between the last bit period and the next rising edge of `dout`.
- `dout`, `ready` and `busy` are all driven from registers, with no combinational path from inputs.

## Configuration
- `RGB_LED_TX_GRB_EN` undefined: transmit order is `colour`[23:0] as given (R, G, B), MSB first.
- `RGB_LED_TX_GRB_EN` defined: the shift register loads {`colour`[15:8], `colour`[23:16], `colour`[7:0]}, so G, R, B are sent, each MSB first. This is for strips with GRB wire order. Timing is identical.

## Structure
- Package `rgb_led_pkg`:
  - `COLOUR_W` = 24 and `BITS_PER_FRAME` = 24;
  - typedef enum `tx_state_t` {IDLE, SEND, LATCH};
  - typedef `colour_t` (logic [23:0]).
- Sub-module `led_bit_timer`:
  - owns the per-bit cycle counter and high/low comparison;
  - inputs: `clk`, `rst`, start, bit value;
  - outputs: registered `dout` level and a bit-done strobe.
- The top level holds the FSM, shift register, bit index and latch counter.

## Test plan
All scenarios use `BIT_CYCLES`=10, `T0H`=3, `T1H`=7, `LATCH_CYCLES`=20.
- Reset release → `dout`=0, `ready`=1, `busy`=0. Holding `valid`=0 for 50 cycles produces no `dout` activity.
- Accept 24'hFF0000 → 8 bits of 7 high / 3 low cycles, then 16 bits of 3 high / 7 low cycles. `ready` returns 260 cycles after the accept edge.
- During that frame, assert `valid` with 24'h00FF00 at cycle 50 → ignored. The waveform still encodes 24'hFF0000 and `ready` timing is unchanged.
- Hold `valid`=1 with 24'hA5A5A5 → two consecutive frames, each encoding 10100101 ×3, separated by exactly 20 low cycles.
- Assert `rst` asynchronously mid-high of bit 10 → `dout` falls without waiting for a clock edge and `ready`=1. The next accept of 24'h000001 sends a fresh full frame from bit 23.
- With `RGB_LED_TX_GRB_EN` defined, accept 24'h123456 → byte order on the wire is 0x34, 0x12, 0x56.
